control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Multi-cycle Moore FSM sequencing the K&S processor. It consumes decoded_instruction and
//  the registered flags from data_path, and drives every data_path/RAM control strobe.
//  Also keeps a saturating retired-instruction counter. Sits beside data_path in the top.
// PARAMETERS
//  CNT_W            16  width of retired_count
//  HALT_ON_ILLEGAL  0   1: undefined decode enters S_HALT; 0: treated as NOP
// PORTS
//  clk                  in   1     clock, all state on rising edge
//  rst_n                in   1     synchronous, ACTIVE-HIGH reset (1 = reset)
//  decoded_instruction  in   enum  decoded_instruction_type from data_path
//  zero_op              in   1     registered zero flag
//  neg_op               in   1     registered negative flag
//  unsigned_overflow    in   1     registered carry/unsigned overflow flag
//  signed_overflow      in   1     registered signed overflow flag
//  branch               out  1     PC mux: 1 = IR address, 0 = PC+1
//  pc_enable            out  1     PC load strobe
//  ir_enable            out  1     IR load strobe
//  addr_sel             out  1     RAM address mux: 0 = PC, 1 = IR mem field
//  c_sel                out  1     reg-write mux: 0 = ALU, 1 = data_in
//  operation            out  2     ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
//  write_reg_enable     out  1     register-file write strobe
//  flags_reg_enable     out  1     flag-register load strobe
//  ram_write_enable     out  1     RAM write strobe
//  halt                 out  1     1 while in S_HALT
//  illegal_instr        out  1     one-cycle pulse in S_DECODE on undefined decode
//  retired_count        out  CNT_W instructions completed since reset, saturates at all-ones
// BEHAVIOUR
//  - Reset: rst_n=1 at posedge -> state S_FETCH, retired_count 0. Takes priority mid-instr.
//    While rst_n=1 all outputs are forced 0. Undriven strobes are 0, branch 0, operation 00.
//  - S_FETCH: addr_sel=0, ir_enable=1 -> S_DECODE.
//  - S_DECODE: pc_enable=1 (PC+1). Next state by decoded_instruction:
//      NOP->S_FETCH. LOAD->S_LOAD1. STORE->S_STORE. MOVE->S_MOVE.
//      ADD/SUB/AND/OR->S_ALU. BRANCH/BZERO/BNZERO/BNEG/BNNEG/BOV/BNOV->S_BRANCH.
//      HALT->S_HALT. Other: illegal_instr=1, then S_HALT if HALT_ON_ILLEGAL else S_FETCH.
//  - S_LOAD1: addr_sel=1 (RAM read, 1-cycle sync latency) -> S_LOAD2.
//  - S_LOAD2: addr_sel=1, c_sel=1, write_reg_enable=1 -> S_FETCH.
//  - S_STORE: addr_sel=1, ram_write_enable=1 -> S_FETCH.
//  - S_ALU: operation per opcode, c_sel=0, write_reg_enable=1, flags_reg_enable=1 -> S_FETCH.
//  - S_MOVE: operation=11 (OR; MOVE encodes both sources as the same reg), c_sel=0,
//    write_reg_enable=1, flags_reg_enable=0 -> S_FETCH.
//  - S_BRANCH: taken = BRANCH | BZERO&zero | BNZERO&~zero | BNEG&neg | BNNEG&~neg |
//    BOV&signed_overflow | BNOV&~signed_overflow. Flags are sampled in S_BRANCH (written by the
//    previous ALU op). Taken: branch=1, pc_enable=1. Not taken: no strobes. -> S_FETCH.
//  - S_HALT: halt=1, all strobes 0, sticky until reset. retired_count frozen.
//  - Cycles/instr: NOP 2, ALU/MOVE/STORE/BRANCH 3, LOAD 4.
//  - retired_count +1 on each transition into S_FETCH from any state except reset,
//    and +1 on entry to S_HALT via HALT. Illegal-as-NOP counts. Held at 2^CNT_W-1.
//  - Only one write strobe (write_reg, ram_write, pc, ir) per cycle, except S_DECODE pc only.
// STRUCTURE
//  - k_and_s_pkg: existing decoded_instruction_type; add ctrl_state_t enum
//    (S_FETCH,S_DECODE,S_LOAD1,S_LOAD2,S_STORE,S_MOVE,S_ALU,S_BRANCH,S_HALT) and ALU op
//    constants OP_ADD/OP_SUB/OP_AND/OP_OR.
//  - Flat module: state register, next-state logic, output decode, counter. No sub-modules.
// TESTING
//  1 Reset, hold decode=NOP: FETCH/DECODE alternate; ir_enable then pc_enable;
//    retired_count=3 after 6 cycles.
//  2 ADD: S_ALU shows operation=00, write_reg_enable=1, flags_reg_enable=1;
//    SUB gives 01; MOVE gives 11 with flags_reg_enable=0.
//  3 LOAD: addr_sel=1 for 2 cycles; c_sel=1 and write_reg_enable=1 only in the 2nd;
//    4 cycles total.
//  4 BZERO with zero_op=1 -> branch=1, pc_enable=1; zero_op=0 -> both 0;
//    repeat BNEG/BOV/BNOV truth table.
//  5 HALT -> halt=1 and stays 20 cycles, no strobes; count frozen;
//    rst_n=1 mid-LOAD1 -> next cycle S_FETCH, count 0.
//  6 CNT_W=2: 5 NOPs -> retired_count saturates at 3;
//    undefined decode pulses illegal_instr; with HALT_ON_ILLEGAL=1 enters halt.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: decoder output encoding, control FSM
// states, ALU operation codes and small decode helpers.
package k_and_s_pkg;

  localparam int unsigned DECODE_W = 5;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 2;

  // Codes above I_HALT are undefined and reach the control unit as illegal.
  typedef enum logic [DECODE_W-1:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_LOAD1,
    S_LOAD2,
    S_STORE,
    S_MOVE,
    S_ALU,
    S_BRANCH,
    S_HALT
  } ctrl_state_t;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  // Branch condition evaluated against the registered ALU flags.
  function automatic logic branch_taken(
    input decoded_instruction_type instr,
    input logic                    zero,
    input logic                    neg,
    input logic                    sovf
  );
    logic taken;
    taken = 1'b0;
    case (instr)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero;
      I_BNZERO: taken = ~zero;
      I_BNEG:   taken = neg;
      I_BNNEG:  taken = ~neg;
      I_BOV:    taken = sovf;
      I_BNOV:   taken = ~sovf;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle Moore control FSM for the K&S processor plus a saturating
// retired-instruction counter.
// Ports:
//   clk, rst_n (synchronous, active-high)  clock and reset
//   decoded_instruction                     decoded IR contents from data_path
//   zero_op/neg_op/unsigned_overflow/signed_overflow  registered ALU flags
//   branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
//   write_reg_enable, flags_reg_enable, ram_write_enable  data_path/RAM strobes
//   halt, illegal_instr                     status
//   retired_count                           completed instructions, saturating
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int unsigned CNT_W           = 16,
  parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [OP_W-1:0]         operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic                    illegal_instr,
  output logic [CNT_W-1:0]        retired_count
);

  ctrl_state_t      state;
  ctrl_state_t      state_next;
  logic [CNT_W-1:0] count;
  logic             count_inc;
  logic             unused_flags;

  // No instruction in this ISA branches on carry.
  assign unused_flags = unsigned_overflow;

  // State register; reset wins even in the middle of an instruction.
  always_ff @(posedge clk) begin
    if (rst_n) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_NOP:    state_next = S_FETCH;
          I_LOAD:   state_next = S_LOAD1;
          I_STORE:  state_next = S_STORE;
          I_MOVE:   state_next = S_MOVE;
          I_ADD, I_SUB, I_AND, I_OR:
                    state_next = S_ALU;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                    state_next = S_BRANCH;
          I_HALT:   state_next = S_HALT;
          default:  state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_LOAD1:  state_next = S_LOAD2;
      S_LOAD2:  state_next = S_FETCH;
      S_STORE:  state_next = S_FETCH;
      S_MOVE:   state_next = S_FETCH;
      S_ALU:    state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = OP_ADD;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    illegal_instr    = 1'b0;
    if (!rst_n) begin
      case (state)
        S_FETCH:  ir_enable = 1'b1;
        S_DECODE: begin
          pc_enable = 1'b1;
          illegal_instr = (decoded_instruction > I_HALT);
        end
        S_LOAD1:  addr_sel = 1'b1;
        S_LOAD2: begin
          addr_sel         = 1'b1;
          c_sel            = 1'b1;
          write_reg_enable = 1'b1;
        end
        S_STORE: begin
          addr_sel         = 1'b1;
          ram_write_enable = 1'b1;
        end
        S_ALU: begin
          case (decoded_instruction)
            I_SUB:   operation = OP_SUB;
            I_AND:   operation = OP_AND;
            I_OR:    operation = OP_OR;
            default: operation = OP_ADD;
          endcase
          write_reg_enable = 1'b1;
          flags_reg_enable = 1'b1;
        end
        // MOVE rd, rs is issued as rs OR rs.
        S_MOVE: begin
          operation        = OP_OR;
          write_reg_enable = 1'b1;
        end
        S_BRANCH: begin
          if (branch_taken(decoded_instruction, zero_op, neg_op, signed_overflow)) begin
            branch    = 1'b1;
            pc_enable = 1'b1;
          end
        end
        S_HALT:   halt = 1'b1;
        default:  ;
      endcase
    end
  end

  // An instruction retires on its return to fetch, or when HALT takes effect.
  assign count_inc = (state_next == S_FETCH) ||
                     ((state == S_DECODE) && (decoded_instruction == I_HALT));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      count <= '0;
    end else if (count_inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  assign retired_count = rst_n ? '0 : count;

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: two instances (wide counter /
// illegal-as-NOP, and 2-bit counter / halt-on-illegal) share one stimulus stream.
module tb_control_unit;
  import k_and_s_pkg::*;

  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;
    logic       illegal_instr;
  } ctl_t;

  typedef struct packed {
    ctl_t        v1;
    ctl_t        v2;
    logic [15:0] c1;
    logic [1:0]  c2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;

  ctl_t        a1, a2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  control_unit #(.CNT_W(16), .HALT_ON_ILLEGAL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow),
    .branch(a1.branch), .pc_enable(a1.pc_enable), .ir_enable(a1.ir_enable),
    .addr_sel(a1.addr_sel), .c_sel(a1.c_sel), .operation(a1.operation),
    .write_reg_enable(a1.write_reg_enable), .flags_reg_enable(a1.flags_reg_enable),
    .ram_write_enable(a1.ram_write_enable), .halt(a1.halt),
    .illegal_instr(a1.illegal_instr), .retired_count(cnt1)
  );

  control_unit #(.CNT_W(2), .HALT_ON_ILLEGAL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow),
    .branch(a2.branch), .pc_enable(a2.pc_enable), .ir_enable(a2.ir_enable),
    .addr_sel(a2.addr_sel), .c_sel(a2.c_sel), .operation(a2.operation),
    .write_reg_enable(a2.write_reg_enable), .flags_reg_enable(a2.flags_reg_enable),
    .ram_write_enable(a2.ram_write_enable), .halt(a2.halt),
    .illegal_instr(a2.illegal_instr), .retired_count(cnt2)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("ctl_a", 32'(a1), 32'(e.v1));
      check("cnt_a", 32'(cnt1), 32'(e.c1));
      check("ctl_b", 32'(a2), 32'(e.v2));
      check("cnt_b", 32'(cnt2), 32'(e.c2));
    end
  end

  // ---------------- reference model ----------------
  int   retired1, retired2;
  bit   halted1, halted2;
  ctl_t zero_v;
  ctl_t halt_v;

  function automatic bit is_legal(input decoded_instruction_type d);
    return int'(d) <= 15;
  endfunction

  // Expected control word for one cycle given both models' halt status.
  task automatic step(input ctl_t v);
    exp_t e;
    e.v1 = halted1 ? halt_v : v;
    e.v2 = halted2 ? halt_v : v;
    e.c1 = 16'(retired1 > 65535 ? 65535 : retired1);
    e.c2 = 2'(retired2 > 3 ? 3 : retired2);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    rst_n = 1'b1;
    e.v1 = zero_v; e.v2 = zero_v; e.c1 = '0; e.c2 = '0;
    for (int k = 0; k < n; k++) begin
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    retired1 = 0; retired2 = 0; halted1 = 0; halted2 = 0;
    rst_n = 1'b0;
  endtask

  // Runs one instruction; abort_at = cycle index to hit with reset,
  // -1 = random reset allowed, -2 = none.
  task automatic run_instr(input decoded_instruction_type d, input int abort_at);
    ctl_t cyc[$];
    ctl_t v;
    bit   z, n, ov, taken;
    z  = 1'($urandom_range(0, 1));
    n  = 1'($urandom_range(0, 1));
    ov = 1'($urandom_range(0, 1));
    decoded_instruction = d;
    zero_op = z; neg_op = n; signed_overflow = ov;
    unsigned_overflow = 1'($urandom_range(0, 1));

    v = zero_v; v.ir_enable = 1; cyc.push_back(v);
    v = zero_v; v.pc_enable = 1; v.illegal_instr = !is_legal(d); cyc.push_back(v);
    case (d)
      I_LOAD: begin
        v = zero_v; v.addr_sel = 1; cyc.push_back(v);
        v.c_sel = 1; v.write_reg_enable = 1; cyc.push_back(v);
      end
      I_STORE: begin
        v = zero_v; v.addr_sel = 1; v.ram_write_enable = 1; cyc.push_back(v);
      end
      I_MOVE: begin
        v = zero_v; v.operation = 2'b11; v.write_reg_enable = 1; cyc.push_back(v);
      end
      I_ADD, I_SUB, I_AND, I_OR: begin
        v = zero_v;
        v.operation = (d == I_ADD) ? 2'b00 : (d == I_SUB) ? 2'b01 :
                      (d == I_AND) ? 2'b10 : 2'b11;
        v.write_reg_enable = 1; v.flags_reg_enable = 1; cyc.push_back(v);
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        case (d)
          I_BRANCH: taken = 1;
          I_BZERO:  taken = z;
          I_BNZERO: taken = !z;
          I_BNEG:   taken = n;
          I_BNNEG:  taken = !n;
          I_BOV:    taken = ov;
          default:  taken = !ov;
        endcase
        v = zero_v; v.branch = taken; v.pc_enable = taken; cyc.push_back(v);
      end
      default: ;
    endcase

    for (int i = 0; i < cyc.size(); i++) begin
      if (i == abort_at || (abort_at == -1 && $urandom_range(0, 59) == 0)) begin
        do_reset(int'($urandom_range(1, 2)));
        return;
      end
      step(cyc[i]);
      if (i == 1 && !is_legal(d)) halted2 = 1;
    end

    if (!halted1) retired1++;
    if (!halted2) retired2++;
    if (d == I_HALT) begin
      halted1 = 1;
      halted2 = 1;
      for (int k = 0; k < 20; k++) step(halt_v);
      do_reset(2);
    end
  endtask

  function automatic decoded_instruction_type pick();
    int r;
    r = int'($urandom_range(0, 39));
    if (r < 2)  return decoded_instruction_type'(5'($urandom_range(16, 31)));
    if (r == 2) return I_HALT;
    return decoded_instruction_type'(5'($urandom_range(0, 14)));
  endfunction

  initial begin
    zero_v = '0;
    halt_v = '0;
    halt_v.halt = 1'b1;
    retired1 = 0; retired2 = 0; halted1 = 0; halted2 = 0;
    rst_n = 1'b1;
    decoded_instruction = I_NOP;
    zero_op = 0; neg_op = 0; unsigned_overflow = 0; signed_overflow = 0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Directed opening: NOP run (saturates the 2-bit counter), ALU/MOVE/LOAD,
    // branch truth tables, reset in LOAD1, illegal decode, then HALT.
    for (int k = 0; k < 5; k++) run_instr(I_NOP, -2);
    run_instr(I_ADD, -2);
    run_instr(I_SUB, -2);
    run_instr(I_MOVE, -2);
    run_instr(I_LOAD, -2);
    run_instr(I_STORE, -2);
    for (int k = 0; k < 4; k++) begin
      run_instr(I_BZERO, -2);
      run_instr(I_BNEG, -2);
      run_instr(I_BOV, -2);
      run_instr(I_BNOV, -2);
    end
    run_instr(I_LOAD, 2);
    run_instr(I_NOP, -2);
    run_instr(decoded_instruction_type'(5'd23), -2);
    run_instr(I_ADD, -2);
    run_instr(I_HALT, -2);

    for (int k = 0; k < 700; k++) run_instr(pick(), -1);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles never checked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
